dbg_req_loader: RTL
===================

DBG_REQ_LOADER -- requirements
Module: dbg_req_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CTRL_ADDR, default 32'hFFFF_0000, control-register address.
REQ-003 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  debug request valid.
REQ-006 SHALL have port req_bits_addr  input  32  debug request byte address.
REQ-007 SHALL have port req_bits_data  input  32  debug request write data.
REQ-008 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port mem_valid  output  1  memory write request valid.
REQ-010 SHALL have port mem_addr  output  32  memory write byte address.
REQ-011 SHALL have port mem_data  output  32  memory write data.
REQ-012 SHALL have port mem_ready  input  1  memory accepts the write when high with mem_valid.
REQ-013 SHALL have port core_reset  output  1  reset to the core, held by this block.
REQ-014 SHALL have port err_misaligned  output  1  sticky misaligned-address flag.
REQ-015 SHALL have port load_count  output  16  completed memory writes, saturating.

Function
REQ-016 SHALL buffer requests in a FIFO of FIFO_DEPTH entries; push on req_valid && req_ready.
REQ-017 SHALL drive req_ready = !full, from registered occupancy only; no combinational path from req_valid or mem_ready.
REQ-018 SHALL present a pushed entry at FIFO head no earlier than the cycle after the push (no bypass).
REQ-019 SHALL allow a push and a pop in the same cycle when not full; occupancy unchanged.
REQ-020 SHALL run FSM IDLE, MEM, CTRL; IDLE with FIFO non-empty and head addr == CTRL_ADDR -> CTRL; head addr[1:0] != 0 -> stay IDLE, pop, set err_misaligned; otherwise -> MEM.
REQ-021 SHALL, in MEM, assert mem_valid with mem_addr/mem_data from a registered copy of the head, holding them stable until mem_ready.
REQ-022 SHALL, on MEM with mem_ready, pop the head, increment load_count, return to IDLE; one write costs at least 2 cycles from head-valid.
REQ-023 SHALL, in CTRL, load core_reset <= data[0], pop the head, return to IDLE next cycle; no memory transaction.
REQ-024 SHALL saturate load_count at 16'hFFFF; no wrap.
REQ-025 SHALL keep err_misaligned set until reset.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full and empty are distinct via occupancy count.
REQ-027 SHALL keep mem_valid low in IDLE and CTRL.

Reset
REQ-028 SHALL, on reset, empty the FIFO, FSM -> IDLE, mem_valid=0, mem_addr=0, mem_data=0, req_ready=0 during reset and 1 the cycle after, core_reset=1, err_misaligned=0, load_count=0.
REQ-029 SHALL abandon an in-flight MEM write on reset mid-transaction; mem_valid low the cycle after reset asserts.

Verification
REQ-030 Single write addr=0x8000_0000 data=0xDEAD_BEEF, mem_ready=1 -> one mem_valid pulse with those values, load_count=1, core_reset stays 1.
REQ-031 mem_ready=0, push 5 requests back-to-back with FIFO_DEPTH=4 -> req_ready low after 4th push, 5th held; release mem_ready -> all 5 written in order, load_count=5.
REQ-032 Write CTRL_ADDR data=0 -> core_reset falls 1->0, no mem_valid, load_count unchanged; then data=1 -> core_reset=1.
REQ-033 Write addr=0x8000_0002 -> no mem_valid, err_misaligned=1 and sticky; following aligned write proceeds normally.
REQ-034 Reset asserted while mem_valid=1, mem_ready=0 -> next cycle mem_valid=0, FIFO empty, core_reset=1, load_count=0.
REQ-035 Force load_count=0xFFFE, complete 3 writes -> load_count=0xFFFF, no wrap.

Source files
------------

// File: rtl/dbg_req_loader.sv
// dbg_req_loader: buffers debug write requests and replays them as memory writes or core-reset control
module dbg_req_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CTRL_ADDR  = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_bits_addr,
    input  logic [31:0] req_bits_data,
    output logic        req_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    output logic        core_reset,
    output logic        err_misaligned,
    output logic [15:0] load_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, MEM, CTRL} state_t;

    state_t        state;
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic          empty;
    logic          misaligned;
    logic          push;
    logic          pop;

    assign empty      = count == '0;
    assign req_ready  = !reset && count != FULL;
    assign push       = req_valid && req_ready;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign misaligned = head_addr != CTRL_ADDR && head_addr[1:0] != 2'b00;
    assign pop        = (state == IDLE && !empty && misaligned) || state == CTRL || (state == MEM && mem_ready);

    // request storage; entries become visible at the head only after the push edge
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= req_bits_addr;
            fifo_data[wr_ptr] <= req_bits_data;
        end
    end

    // pointers wrap naturally at the power-of-two depth; count disambiguates full from empty
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // dispatch the head: memory write, control-register update, or drop with error
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            mem_valid      <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            core_reset     <= 1'b1;
            err_misaligned <= 1'b0;
            load_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_addr == CTRL_ADDR) begin
                            state <= CTRL;
                        end else if (misaligned) begin
                            err_misaligned <= 1'b1;
                        end else begin
                            state     <= MEM;
                            mem_valid <= 1'b1;
                            mem_addr  <= head_addr;
                            mem_data  <= head_data;
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_valid  <= 1'b0;
                        load_count <= load_count == 16'hFFFF ? load_count : load_count + 16'd1;
                    end
                end
                CTRL: begin
                    core_reset <= head_data[0];
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
